// File: rtl/ls_issue_queue.sv
// In-order LW/SW issue queue: tracks operand tags via CDB snoop and issues the head entry to the memory unit.
// Optional LSQ_STALL_CNT_EN adds a saturating stall_count output.
module ls_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dispatch_valid,
  input  logic                       dispatch_opcode,
  input  logic [DATA_W-1:0]          dispatch_rs_data,
  input  logic [TAG_W-1:0]           dispatch_rs_tag,
  input  logic                       dispatch_rs_valid,
  input  logic [DATA_W-1:0]          dispatch_rt_data,
  input  logic [TAG_W-1:0]           dispatch_rt_tag,
  input  logic                       dispatch_rt_valid,
  input  logic [DATA_W-1:0]          dispatch_imm,
  input  logic [TAG_W-1:0]           dispatch_rd_tag,
  output logic                       queue_full,
  output logic [$clog2(DEPTH):0]     queue_count,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic                       mem_grant,
  input  logic                       flush,
  output logic                       issueblk_done,
  output logic                       issueque_opcode,
  output logic [DATA_W-1:0]          issueque_rs_data,
  output logic [DATA_W-1:0]          issueque_rt_data,
  output logic [DATA_W-1:0]          issueque_imm,
  output logic [TAG_W-1:0]           issueque_rd_tag
`ifdef LSQ_STALL_CNT_EN
  ,
  output logic [15:0]                stall_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // control state
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_rs_rdy;
  logic [DEPTH-1:0]  r_rt_rdy;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_done;
  logic              r_iq_op;
  logic [DATA_W-1:0] r_iq_rs;
  logic [DATA_W-1:0] r_iq_rt;
  logic [DATA_W-1:0] r_iq_imm;
  logic [TAG_W-1:0]  r_iq_rd;

  // entry payload
  logic              r_op      [DEPTH];
  logic [DATA_W-1:0] r_rs_data [DEPTH];
  logic [TAG_W-1:0]  r_rs_tag  [DEPTH];
  logic [DATA_W-1:0] r_rt_data [DEPTH];
  logic [TAG_W-1:0]  r_rt_tag  [DEPTH];
  logic [DATA_W-1:0] r_imm     [DEPTH];
  logic [TAG_W-1:0]  r_rd_tag  [DEPTH];

  logic              w_full;
  logic              w_accept;
  logic              w_head_ready;
  logic              w_issue;
  logic              w_rs_byp;
  logic              w_rt_byp;
  logic              w_rs_rdy_in;
  logic              w_rt_rdy_in;
  logic [DATA_W-1:0] w_rs_data_in;
  logic [DATA_W-1:0] w_rt_data_in;
  logic [DEPTH-1:0]  w_rs_hit;
  logic [DEPTH-1:0]  w_rt_hit;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_accept = dispatch_valid && !w_full;

  // Readiness uses registered flags only, so a same-cycle CDB capture cannot trigger issue.
  assign w_head_ready = r_valid[r_head] && r_rs_rdy[r_head] && (!r_op[r_head] || r_rt_rdy[r_head]);
  assign w_issue      = w_head_ready && mem_grant;

  assign w_rs_byp     = !dispatch_rs_valid && cdb_valid && (cdb_tag == dispatch_rs_tag);
  assign w_rt_byp     = !dispatch_rt_valid && cdb_valid && (cdb_tag == dispatch_rt_tag);
  assign w_rs_rdy_in  = dispatch_rs_valid || w_rs_byp;
  assign w_rt_rdy_in  = dispatch_rt_valid || w_rt_byp;
  assign w_rs_data_in = w_rs_byp ? cdb_data : dispatch_rs_data;
  assign w_rt_data_in = w_rt_byp ? cdb_data : dispatch_rt_data;

  always_comb begin
    w_rs_hit = '0;
    w_rt_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_rs_hit[i] = cdb_valid && r_valid[i] && !r_rs_rdy[i] && (r_rs_tag[i] == cdb_tag);
      w_rt_hit[i] = cdb_valid && r_valid[i] && !r_rt_rdy[i] && (r_rt_tag[i] == cdb_tag);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_rs_rdy <= '0;
      r_rt_rdy <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_iq_op  <= 1'b0;
      r_iq_rs  <= '0;
      r_iq_rt  <= '0;
      r_iq_imm <= '0;
      r_iq_rd  <= '0;
    end else if (flush) begin
      r_valid  <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_issue;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_rs_hit[i]) r_rs_rdy[i] <= 1'b1;
        if (w_rt_hit[i]) r_rt_rdy[i] <= 1'b1;
      end
      if (w_issue) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_iq_op         <= r_op[r_head];
        r_iq_rs         <= r_rs_data[r_head];
        r_iq_rt         <= r_rt_data[r_head];
        r_iq_imm        <= r_imm[r_head];
        r_iq_rd         <= r_rd_tag[r_head];
      end
      if (w_accept) begin
        r_valid[r_tail]  <= 1'b1;
        r_rs_rdy[r_tail] <= w_rs_rdy_in;
        r_rt_rdy[r_tail] <= w_rt_rdy_in;
        r_tail           <= r_tail + 1'b1;
      end
      case ({w_accept, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: the valid/ready flags above gate all use of it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_rs_hit[i]) r_rs_data[i] <= cdb_data;
      if (w_rt_hit[i]) r_rt_data[i] <= cdb_data;
    end
    if (w_accept) begin
      r_op[r_tail]      <= dispatch_opcode;
      r_rs_data[r_tail] <= w_rs_data_in;
      r_rs_tag[r_tail]  <= dispatch_rs_tag;
      r_rt_data[r_tail] <= w_rt_data_in;
      r_rt_tag[r_tail]  <= dispatch_rt_tag;
      r_imm[r_tail]     <= dispatch_imm;
      r_rd_tag[r_tail]  <= dispatch_rd_tag;
    end
  end

`ifdef LSQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // A flush cycle is not counted as a stall since the head is being discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!flush && w_head_ready && !mem_grant && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

  assign queue_full       = w_full;
  assign queue_count      = r_count;
  assign issueblk_done    = r_done;
  assign issueque_opcode  = r_iq_op;
  assign issueque_rs_data = r_iq_rs;
  assign issueque_rt_data = r_iq_rt;
  assign issueque_imm     = r_iq_imm;
  assign issueque_rd_tag  = r_iq_rd;

endmodule

// File: tb/tb_ls_issue_queue.sv
// Self-checking bench for ls_issue_queue: scoreboard of expected issues plus cycle-level timing checks.
module tb_ls_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_valid, dispatch_opcode, dispatch_rs_valid, dispatch_rt_valid;
  logic [31:0] dispatch_rs_data, dispatch_rt_data, dispatch_imm;
  logic [5:0]  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag;
  logic        queue_full;
  logic [2:0]  queue_count;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        mem_grant, flush;
  logic        issueblk_done, issueque_opcode;
  logic [31:0] issueque_rs_data, issueque_rt_data, issueque_imm;
  logic [5:0]  issueque_rd_tag;
`ifdef LSQ_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  ls_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_rs_data(dispatch_rs_data), .dispatch_rs_tag(dispatch_rs_tag),
    .dispatch_rs_valid(dispatch_rs_valid), .dispatch_rt_data(dispatch_rt_data),
    .dispatch_rt_tag(dispatch_rt_tag), .dispatch_rt_valid(dispatch_rt_valid),
    .dispatch_imm(dispatch_imm), .dispatch_rd_tag(dispatch_rd_tag),
    .queue_full(queue_full), .queue_count(queue_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mem_grant(mem_grant), .flush(flush),
    .issueblk_done(issueblk_done), .issueque_opcode(issueque_opcode),
    .issueque_rs_data(issueque_rs_data), .issueque_rt_data(issueque_rt_data),
    .issueque_imm(issueque_imm), .issueque_rd_tag(issueque_rd_tag)
`ifdef LSQ_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [5:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic op, input logic rs_v, input logic [31:0] rs, input logic [5:0] rs_tag,
                      input logic rt_v, input logic [31:0] rt, input logic [5:0] rt_tag,
                      input logic [31:0] imm, input logic [5:0] rd);
    dispatch_valid    = 1'b1;
    dispatch_opcode   = op;
    dispatch_rs_valid = rs_v;
    dispatch_rs_data  = rs;
    dispatch_rs_tag   = rs_tag;
    dispatch_rt_valid = rt_v;
    dispatch_rt_data  = rt;
    dispatch_rt_tag   = rt_tag;
    dispatch_imm      = imm;
    dispatch_rd_tag   = rd;
  endtask

  task automatic push(input logic op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] imm, input logic [5:0] rd);
    exp_t e;
    e.op = op; e.rs = rs; e.rt = rt; e.imm = imm; e.rd = rd;
    sb.push_back(e);
  endtask

  // Issue monitor: every issue pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (issueblk_done) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 64'(issueque_rd_tag), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("iss_op",  64'(issueque_opcode),  64'(e.op));
        check("iss_rs",  64'(issueque_rs_data), 64'(e.rs));
        check("iss_rt",  64'(issueque_rt_data), 64'(e.rt));
        check("iss_imm", 64'(issueque_imm),     64'(e.imm));
        check("iss_rd",  64'(issueque_rd_tag),  64'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; mem_grant = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    step(); step();
    check("rst_count", 64'(queue_count), 0);
    check("rst_full",  64'(queue_full), 0);
    check("rst_done",  64'(issueblk_done), 0);
    check("rst_rs",    64'(issueque_rs_data), 0);
    check("rst_rt",    64'(issueque_rt_data), 0);
    check("rst_imm",   64'(issueque_imm), 0);
    check("rst_rd",    64'(issueque_rd_tag), 0);
    check("rst_op",    64'(issueque_opcode), 0);
    rst = 1'b0;

    // ready LW: write edge, then issue edge
    mem_grant = 1'b1;
    disp(0, 1, 32'h10, 0, 1, 0, 0, 32'h4, 6'd5);
    push(0, 32'h10, 0, 32'h4, 6'd5);
    step(); dispatch_valid = 1'b0;
    check("t1_cnt_after_write", 64'(queue_count), 1);
    check("t1_done_early", 64'(issueblk_done), 0);
    step();
    check("t1_done", 64'(issueblk_done), 1);
    check("t1_cnt_after_issue", 64'(queue_count), 0);
    step();
    check("t1_done_pulse", 64'(issueblk_done), 0);

    // SW waiting on rt via CDB
    disp(1, 1, 32'h20, 0, 0, 32'h0, 6'd9, 32'h8, 6'd7);
    push(1, 32'h20, 32'hDEAD, 32'h8, 6'd7);
    step(); dispatch_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEAD;
    check("t2_done_before_cdb", 64'(issueblk_done), 0);
    step(); cdb_valid = 1'b0;
    check("t2_no_issue_on_capture", 64'(issueblk_done), 0);
    step();
    check("t2_done", 64'(issueblk_done), 1);
    step();

    // in-order: B ready behind unready A
    disp(0, 0, 32'hBAD, 6'd3, 1, 0, 0, 32'h1, 6'd11);
    push(0, 32'h333, 0, 32'h1, 6'd11);
    step();
    disp(0, 1, 32'h30, 0, 1, 0, 0, 32'h2, 6'd12);
    push(0, 32'h30, 0, 32'h2, 6'd12);
    step(); dispatch_valid = 1'b0;
    check("t3_cnt", 64'(queue_count), 2);
    step();
    check("t3_no_bypass", 64'(issueblk_done), 0);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h333;
    step(); cdb_valid = 1'b0;
    check("t3_no_issue_on_capture", 64'(issueblk_done), 0);
    step();
    check("t3_A_done", 64'(issueblk_done), 1);
    step();
    check("t3_B_done", 64'(issueblk_done), 1);
    step();
    check("t3_idle", 64'(issueblk_done), 0);
    check("t3_cnt_end", 64'(queue_count), 0);

    // fill, reject while full, drain in order with wrap
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(i[0], 1, 32'h100 + 32'(i), 0, 1, 32'h200 + 32'(i), 0, 32'(i), 6'(20 + i));
      push(i[0], 32'h100 + 32'(i), 32'h200 + 32'(i), 32'(i), 6'(20 + i));
      step();
    end
    check("t4_full", 64'(queue_full), 1);
    check("t4_cnt4", 64'(queue_count), 4);
    disp(0, 1, 32'hEEE, 0, 1, 0, 0, 32'hEE, 6'd63);
    step();
    check("t4_cnt_reject", 64'(queue_count), 4);
    check("t4_no_issue", 64'(issueblk_done), 0);
    mem_grant = 1'b1;
    step();
    check("t4_done1", 64'(issueblk_done), 1);
    check("t4_cnt_same_cycle_reject", 64'(queue_count), 3);
    check("t4_full_drop", 64'(queue_full), 0);
    disp(1, 1, 32'h300, 0, 1, 32'h301, 0, 32'h30, 6'd30);
    push(1, 32'h300, 32'h301, 32'h30, 6'd30);
    step(); dispatch_valid = 1'b0;
    check("t4_cnt_disp_and_issue", 64'(queue_count), 3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_drain_done", 64'(issueblk_done), 1);
    end
    step();
    check("t4_drain_idle", 64'(issueblk_done), 0);
    check("t4_cnt_end", 64'(queue_count), 0);

    // flush beats dispatch and issue
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(0, 1, 32'h400 + 32'(i), 0, 1, 0, 0, 0, 6'(40 + i));
      step();
    end
    check("t5_cnt3", 64'(queue_count), 3);
    disp(0, 1, 32'h555, 0, 1, 0, 0, 0, 6'd55);
    flush = 1'b1; mem_grant = 1'b1;
    step(); flush = 1'b0; dispatch_valid = 1'b0;
    check("t5_cnt_flush", 64'(queue_count), 0);
    check("t5_done_flush", 64'(issueblk_done), 0);
    check("t5_full_flush", 64'(queue_full), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_issue", 64'(issueblk_done), 0);
    end

`ifdef LSQ_STALL_CNT_EN
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_stall_rst", 64'(stall_count), 0);
    mem_grant = 1'b0;
    disp(0, 1, 32'h600, 0, 1, 0, 0, 0, 6'd60);
    step(); dispatch_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t6_stall7", 64'(stall_count), 7);
    flush = 1'b1;
    step(); flush = 1'b0;
    step();
    check("t6_stall_after_flush", 64'(stall_count), 7);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_stall_cleared", 64'(stall_count), 0);
`endif

    step(); step();
    check("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ls_issue_queue.md
Name: ls_issue_queue

Overview:
In-order load/store issue queue and scheduler that feeds the memory execution unit. It accepts dispatched LW/SW instructions and tracks source operand tags by snooping the CDB. It issues the oldest entry to the memory unit once that entry's operands are ready and the memory unit's CDB slot is granted. It sits between dispatch/rename and the memory execution unit and replaces direct dispatch-to-memory wiring.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
TAG_W, 6, width of ROB/rename tags carried on the CDB
DATA_W, 32, operand/data width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
dispatch_valid  input  1  dispatch slot carries a LW/SW this cycle
dispatch_opcode  input  1  1=SW, 0=LW
dispatch_rs_data  input  DATA_W  base register value (valid if dispatch_rs_valid)
dispatch_rs_tag  input  TAG_W  producer tag of base register
dispatch_rs_valid  input  1  base operand already available
dispatch_rt_data  input  DATA_W  store data value (SW only)
dispatch_rt_tag  input  TAG_W  producer tag of store data
dispatch_rt_valid  input  1  store data already available
dispatch_imm  input  DATA_W  sign-extended offset
dispatch_rd_tag  input  TAG_W  destination tag (LW only)
queue_full  output  1  no free entry; dispatch must stall
queue_count  output  $clog2(DEPTH)+1  occupied entries
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB broadcast tag
cdb_data  input  DATA_W  CDB broadcast data
mem_grant  input  1  memory unit may drive the CDB next cycle
flush  input  1  branch mispredict; discard all entries
issueblk_done  output  1  issue stage register valid (one-cycle pulse per issue)
issueque_opcode  output  1  issued opcode
issueque_rs_data  output  DATA_W  issued base value
issueque_rt_data  output  DATA_W  issued store data
issueque_imm  output  DATA_W  issued offset
issueque_rd_tag  output  TAG_W  issued destination tag

Behaviour:
- Reset: all entries invalid; head = tail = 0; queue_count = 0; queue_full = 0; issueblk_done = 0; all issueque_* = 0.
- Storage: circular buffer with head and tail pointers; wrap modulo DEPTH. queue_count is a separate counter.
- Dispatch:
  - Accepted when dispatch_valid && !queue_full. Written at tail; tail advances.
  - Dispatch while full is ignored; the queue does not change.
- Entry ready condition:
  - LW: rs ready.
  - SW: rs ready and rt ready.
  - rt readiness is ignored for LW.
- CDB snoop:
  - Every valid entry with an unready operand whose tag equals cdb_tag while cdb_valid=1 captures cdb_data and marks it ready at the clock edge.
  - Same-cycle bypass: a dispatching entry whose unready tag matches the current CDB broadcast is written already ready, with cdb_data.
- Issue:
  - Strictly in order, head entry only. No younger entry bypasses an older one, so memory ordering is preserved.
  - Issue fires when head is valid and ready and mem_grant=1.
  - On the issuing edge: issueque_* are loaded from the head entry, issueblk_done=1 for exactly one cycle, head advances, and the entry is freed.
  - When no issue fires: issueblk_done=0 and issueque_* hold their last values.
- Latency: an entry dispatched with all operands ready and mem_grant held high has issueblk_done high 2 cycles after its dispatch edge (write edge, then issue edge).
- Simultaneous dispatch and issue: both happen and queue_count is unchanged. When full, the issue frees a slot, but the dispatch in the same cycle is still rejected because queue_full is based on the registered count.
- Snoop and issue in the same cycle: the head is not ready until the edge after capture, so no issue fires off un-latched CDB data.
- flush:
  - Synchronously invalidates all entries, zeroes pointers and count, and clears issueblk_done.
  - Dispatch in the same cycle is dropped.
  - Priority: rst > flush > issue/dispatch.
- Reset asserted mid-operation discards everything in the same edge.

Optional Feature:
LSQ_STALL_CNT_EN
- Defined: adds output stall_count (16 bits). It increments, saturating at 0xFFFF, on every cycle in which the head is valid and ready but mem_grant=0. It is cleared by rst only, not by flush.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset, then dispatch LW rs_valid=1, rs=0x10, imm=0x4, rd_tag=5, mem_grant=1 -> issueblk_done one cycle, 2 cycles after the dispatch edge, with rs_data=0x10, imm=0x4, rd_tag=5, opcode=0; queue_count back to 0.
- Dispatch SW with rs ready and rt_tag=9 unready; one cycle later CDB tag=9, data=0xDEAD -> issue occurs on the edge after capture with rt_data=0xDEAD; no earlier issue.
- Dispatch LW A (rs unready, tag 3), then LW B (ready) -> B is not issued before A. Broadcast tag 3 -> A issues, then B on the next cycle.
- Fill DEPTH=4 entries with mem_grant=0 -> queue_full=1 and a fifth dispatch is ignored. Raise mem_grant -> entries issue in order, one per cycle; queue_full drops after the first issue and the pointers wrap correctly.
- With 3 entries queued, assert flush together with a dispatch -> queue_count=0, issueblk_done=0 the next cycle, and the dropped dispatch never issues.
- With LSQ_STALL_CNT_EN defined: hold a ready head with mem_grant=0 for 7 cycles -> stall_count=7; flush leaves it at 7; rst clears it to 0.
